// File: rtl/leitor_mem.sv
// Circular history of committed 8-bit saves, replayed oldest-to-newest on request.
// Each replayed entry is held on rd_data for HOLD cycles; all outputs are registered.
module leitor_mem #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       okSAVE,
    input  logic [7:0]                 num,
    input  logic                       okREAD,
    input  logic                       clear,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    output logic                       rd_last,
    output logic                       done,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       save_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] base_q, base_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] n_q, n_d;
    logic [PW-1:0] idx_q, idx_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          save_drop_q, save_drop_d;
    logic [PW-1:0] next_idx;

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        base_d      = base_q;
        count_d     = count_q;
        n_d         = n_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        save_drop_d = 1'b0;
        next_idx    = idx_q + PW'(1);

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    count_d     = '0;
                    wr_ptr_d    = '0;
                    base_d      = '0;
                    save_drop_d = okSAVE;
                end else if (okREAD) begin
                    save_drop_d = okSAVE;
                    busy_d      = 1'b1;
                    if (count_q == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_SHOW;
                        n_d        = count_q;
                        idx_d      = '0;
                        hold_d     = '0;
                        rd_data_d  = mem_q[base_q];
                        rd_valid_d = 1'b1;
                        rd_last_d  = (count_q == CW'(1));
                    end
                end else if (okSAVE) begin
                    mem_d[wr_ptr_q] = num;
                    wr_ptr_d        = wr_ptr_q + PW'(1);
                    // A full buffer overwrites its oldest entry, so the oldest pointer moves on.
                    if (count_q < CW'(DEPTH)) begin
                        count_d = count_q + CW'(1);
                    end else begin
                        base_d = base_q + PW'(1);
                    end
                end
            end
            S_SHOW: begin
                save_drop_d = okSAVE;
                if (hold_q == HW'(HOLD - 1)) begin
                    hold_d = '0;
                    if (CW'(idx_q) == n_q - CW'(1)) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                    end else begin
                        idx_d     = next_idx;
                        rd_data_d = mem_q[base_q + next_idx];
                        rd_last_d = (CW'(next_idx) == n_q - CW'(1));
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_DONE: begin
                save_drop_d = okSAVE;
                state_d     = S_IDLE;
                busy_d      = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stored data is left unreset; count and pointers define which slots are meaningful.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            count_q     <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            save_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            base_q      <= base_d;
            count_q     <= count_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            save_drop_q <= save_drop_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign count     = count_q;
    assign save_drop = save_drop_q;

endmodule

// File: tb/tb_leitor_mem.sv
// Scoreboard bench for leitor_mem: a queue-based history model predicts every replayed
// cycle, a monitor pops predictions whenever the DUT shows rd_valid or done.
module tb_leitor_mem;

    localparam int DEPTH = 4;
    localparam int HOLD  = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          okSAVE;
    logic [7:0]    num;
    logic          okREAD;
    logic          clear;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic          done;
    logic          busy;
    logic [CW-1:0] count;
    logic          save_drop;

    leitor_mem #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .okSAVE    (okSAVE),
        .num       (num),
        .okREAD    (okREAD),
        .clear     (clear),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .done      (done),
        .busy      (busy),
        .count     (count),
        .save_drop (save_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       isDone;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] hist[$];
    int         busyLeft   = 0;
    logic       expDrop    = 1'b0;
    logic       afterReset = 1'b1;
    int         checks     = 0;
    int         failures   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents an entry or a done pulse, pop one prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1 || done === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    if (e.isDone) begin
                        checkOutput("done_pulse", 32'(done), 32'd1);
                        checkOutput("valid_at_done", 32'(rd_valid), 32'd0);
                    end else begin
                        checkOutput("rd_valid", 32'(rd_valid), 32'd1);
                        checkOutput("rd_data", 32'(rd_data), 32'(e.data));
                        checkOutput("rd_last", 32'(rd_last), 32'(e.last));
                    end
                end
            end
        end
    end

    // One cycle: check the current cycle against the model, then update the model and drive inputs.
    task automatic applyStimulus(input logic sv, input logic [7:0] v, input logic rd,
                                 input logic clr, input logic rst);
        exp_t e;
        int   n;
        @(negedge clk);
        #1;
        checkOutput("busy", 32'(busy), 32'(busyLeft > 0));
        checkOutput("count", 32'(count), 32'(hist.size()));
        checkOutput("save_drop", 32'(save_drop), 32'(expDrop));
        if (afterReset) begin
            checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
            checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
            checkOutput("reset_rd_last", 32'(rd_last), 32'd0);
            checkOutput("reset_done", 32'(done), 32'd0);
        end
        expDrop    = 1'b0;
        afterReset = 1'b0;
        if (rst) begin
            hist.delete();
            expQ.delete();
            busyLeft   = 0;
            afterReset = 1'b1;
        end else if (busyLeft > 0) begin
            busyLeft--;
            expDrop = sv;
        end else if (clr) begin
            hist.delete();
            expDrop = sv;
        end else if (rd) begin
            expDrop = sv;
            n = hist.size();
            for (int k = 0; k < n; k++) begin
                for (int h = 0; h < HOLD; h++) begin
                    e.isDone = 1'b0;
                    e.data   = hist[k];
                    e.last   = (k == n - 1);
                    expQ.push_back(e);
                end
            end
            e.isDone = 1'b1;
            e.data   = 8'h00;
            e.last   = 1'b0;
            expQ.push_back(e);
            busyLeft = n * HOLD + 1;
        end else if (sv) begin
            hist.push_back(v);
            if (hist.size() > DEPTH) begin
                void'(hist.pop_front());
            end
        end
        reset  = rst;
        okSAVE = sv;
        num    = v;
        okREAD = rd;
        clear  = clr;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic save(input logic [7:0] v);
        applyStimulus(1'b1, v, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int drainBudget;
        reset  = 1'b1;
        okSAVE = 1'b0;
        num    = 8'h00;
        okREAD = 1'b0;
        clear  = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(2);

        $display("[TB] empty read");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(3);

        $display("[TB] basic replay");
        save(8'h11);
        save(8'h22);
        save(8'h33);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(3 * HOLD + 3);

        $display("[TB] wrap-around");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            save(8'(i));
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(4 * HOLD + 3);

        $display("[TB] save during replay");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        save(8'h41);
        save(8'h42);
        save(8'h43);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(1);
        save(8'hAA);
        idle(3 * HOLD + 2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(3 * HOLD + 3);

        $display("[TB] reset mid-replay");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(HOLD + 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(3);

        $display("[TB] clear vs read");
        save(8'h5A);
        save(8'hA5);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(3);
        save(8'h66);
        save(8'h77);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        idle(2 * HOLD + 2);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 1500; c++) begin
            applyStimulus($urandom_range(0, 99) < 45, 8'($urandom),
                          $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3,
                          $urandom_range(0, 199) == 0);
        end

        drainBudget = 0;
        while (busyLeft > 0 && drainBudget < 200) begin
            idle(1);
            drainBudget++;
        end
        idle(3);
        checkOutput("pending_predictions", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
